serial_operand_tx: RTL

- Parallel-to-serial operand transmitter for the bit-serial adder datapath.
- Accepts one parallel operand pair (A, B, carry-in) from an upstream word handshake.
- Requests the serial sink with valid/ready, then streams both operands LSB-first, one bit per enabled cycle, on two lanes.
- Sits in front of the serial adder and drives its din_a/din_b/cin/valid inputs.

---
 rtl/serial_pkg.sv | 18 +
 rtl/piso_shift_reg.sv | 41 ++++
 rtl/serial_operand_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial operand transmitter.
// The optional one-word prefetch buffer is enabled with SERIAL_OPERAND_TX_PREFETCH_EN.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } tx_state_t;

   localparam int DEFAULT_DATA_WIDTH = 16;

   // Bit-counter width; never below 1 so the counter always has a real bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. Parallel load has priority over
// shifting; shifting moves toward the LSB with zero fill.
module piso_shift_reg #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_lsb
);

   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_d;

   // Next contents: load wins over shift, both gated by the clock enable.
   always_comb begin
      sh_d = sh_q;
      if (i_en) begin
         if (i_load) begin
            sh_d = i_data;
         end else if (i_shift) begin
            sh_d = {1'b0, sh_q[WIDTH-1:1]};
         end
      end
   end

   // Register the shift contents.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign o_lsb = sh_q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand transmitter feeding the bit-serial adder.
// Captures an (A, B, cin) word, requests the sink with o_valid, then streams
// both operands LSB-first as an uninterruptible burst once i_ready is seen.
// Define SERIAL_OPERAND_TX_PREFETCH_EN to add a one-word holding register so
// the next word can be accepted while a frame is in flight.
//
// state | meaning
// IDLE  | no frame; word handshake open
// REQ   | word loaded, o_valid high, waiting for i_ready
// SEND  | streaming bit cnt on the lanes, one bit per enabled edge
module serial_operand_tx
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_word_a,
   input  logic [DATA_WIDTH-1:0] i_word_b,
   input  logic                  i_word_cin,
   input  logic                  i_word_valid,
   output logic                  o_word_ready,
   output logic                  o_din_a,
   output logic                  o_din_b,
   output logic                  o_cin,
   output logic                  o_valid,
   input  logic                  i_ready
);

   localparam int             CW       = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

   tx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            cin_q, cin_d;

   logic                  accept;
   logic                  load_sh;
   logic                  shift_sh;
   logic [DATA_WIDTH-1:0] load_a;
   logic [DATA_WIDTH-1:0] load_b;

`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
   logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d;
   logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;
   logic                  hold_cin_q, hold_cin_d;
   logic                  hold_full_q, hold_full_d;

   assign o_word_ready = !hold_full_q && i_en && i_rst_n;
`else
   assign o_word_ready = (state_q == IDLE) && i_en && i_rst_n;
`endif

   assign accept = i_word_valid && o_word_ready;

   // Next-state, counter and shift-register control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      cin_d    = cin_q;
      load_sh  = 1'b0;
      shift_sh = 1'b0;
      load_a   = i_word_a;
      load_b   = i_word_b;
`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
      hold_a_d    = hold_a_q;
      hold_b_d    = hold_b_q;
      hold_cin_d  = hold_cin_q;
      hold_full_d = hold_full_q;
`endif
      if (i_en) begin
         case (state_q)
            IDLE: begin
`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
               // A word parked on the final edge of the last frame starts here.
               if (hold_full_q) begin
                  load_sh     = 1'b1;
                  load_a      = hold_a_q;
                  load_b      = hold_b_q;
                  cin_d       = hold_cin_q;
                  hold_full_d = 1'b0;
                  state_d     = REQ;
                  valid_d     = 1'b1;
               end else
`endif
               if (accept) begin
                  load_sh = 1'b1;
                  cin_d   = i_word_cin;
                  state_d = REQ;
                  valid_d = 1'b1;
               end
            end
            REQ: begin
               if (i_ready) begin
                  state_d = SEND;
                  cnt_d   = '0;
               end
            end
            SEND: begin
               shift_sh = 1'b1;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  valid_d = 1'b0;
`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
                  if (hold_full_q) begin
                     load_sh     = 1'b1;
                     load_a      = hold_a_q;
                     load_b      = hold_b_q;
                     cin_d       = hold_cin_q;
                     hold_full_d = 1'b0;
                     state_d     = REQ;
                     valid_d     = 1'b1;
                  end
`endif
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
         // Accept only happens with an empty buffer, so this never collides
         // with the buffer being drained above.
         if (accept && (state_q != IDLE)) begin
            hold_a_d    = i_word_a;
            hold_b_d    = i_word_b;
            hold_cin_d  = i_word_cin;
            hold_full_d = 1'b1;
         end
`endif
      end
   end

   // Control registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         cin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         cin_q   <= cin_d;
      end
   end

`ifdef SERIAL_OPERAND_TX_PREFETCH_EN
   // Holding register for the prefetched word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         hold_cin_q  <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         hold_cin_q  <= hold_cin_d;
         hold_full_q <= hold_full_d;
      end
   end
`endif

   piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_sh_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_load  (load_sh),
      .i_shift (shift_sh),
      .i_data  (load_a),
      .o_lsb   (o_din_a)
   );

   piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_sh_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_load  (load_sh),
      .i_shift (shift_sh),
      .i_data  (load_b),
      .o_lsb   (o_din_b)
   );

   assign o_cin   = cin_q;
   assign o_valid = valid_q;

endmodule
